block_interleaver: RTL and testbench
====================================

BLOCK_INTERLEAVER -- requirements
Module: block_interleaver

Interface
REQ-001 SHALL have parameter ROWS, default 8, number of interleaver rows (power of two, >=2).
REQ-002 SHALL have parameter COLS, default 8, number of interleaver columns (power of two, >=2); block length N = ROWS*COLS.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port bit_in  input  1  encoded bit from encoder, qualified by valid_in.
REQ-006 SHALL have port valid_in  input  1  one-cycle strobe per input bit.
REQ-007 SHALL have port sof_in  input  1  first bit of an encoder block, qualified by valid_in.
REQ-008 SHALL have port bit_out  output  1  interleaved bit to modulator.
REQ-009 SHALL have port valid_out  output  1  one-cycle strobe per output bit.
REQ-010 SHALL have port sof_out  output  1  first bit of an interleaved block, qualified by valid_out.
REQ-011 SHALL have port sync_err  output  1  one-cycle pulse on block misalignment.

Function
REQ-012 SHALL hold two N-bit banks (ping-pong); wsel selects write bank, other bank is read bank.
REQ-013 SHALL keep write counter wcnt (0..N-1), advanced only on valid_in, wrapping N-1 -> 0.
REQ-014 SHALL write bit_in on valid_in into bank[wsel] at row-major index wcnt (row = wcnt div COLS, col = wcnt mod COLS).
REQ-015 SHALL, on valid_in with wcnt = N-1, toggle wsel and set primed = 1.
REQ-016 SHALL, on valid_in while primed, read bank[~wsel] at index (k mod ROWS)*COLS + (k div ROWS), k = wcnt (column-major readout), same cadence as input.
REQ-017 SHALL register the read result: bit_out and valid_out = 1 exactly one clk after the qualifying valid_in; sof_out = 1 alongside when k = 0.
REQ-018 SHALL hold bit_out at its last value, and drive valid_out = 0 and sof_out = 0, in cycles without a qualifying read.
REQ-019 SHALL give latency of exactly one block: bit j of block b appears in block b+1 output at position k = (j mod COLS)*ROWS + (j div COLS).
REQ-020 SHALL ignore sof_in when wcnt = 0 (aligned).
REQ-021 SHALL, on valid_in & sof_in with wcnt != 0: write this bit at index 0, set wcnt = 1, clear primed, suppress valid_out for this bit, and pulse sync_err one clk later.
REQ-022 SHALL ignore sof_in and bit_in without valid_in.
REQ-023 SHALL support valid_in every cycle (no gaps in output) and arbitrary gaps between strobes.

Reset
REQ-024 SHALL, when rst = 0 at a clk edge, set wcnt = 0, wsel = 0, primed = 0, bit_out = 0, valid_out = 0, sof_out = 0, sync_err = 0.
REQ-025 SHALL give reset priority over valid_in; reset mid-block discards both banks logically (contents need not be cleared).
REQ-026 SHALL, after reset release, produce no valid_out until N further valid_in strobes are accepted.

Structure
REQ-027 SHALL take ROWS, COLS, N and address width log2(N) from the shared comms package used by encoder and modulator.
REQ-028 SHALL implement the write/read index generation in one sub-module, interleave_addr_gen (wcnt in, write index and column-major read index out, combinational).
REQ-029 SHALL infer banks as plain register arrays or distributed RAM, one write and one read port each.

Verification
REQ-030 Reset: rst = 0 for 5 clk with valid_in toggling -> all outputs 0; after release, first 64 valid_in give no valid_out.
REQ-031 Single-one: block 0 with only bit j = 1 set (row 0, col 1), then 64 zeros -> in block 1 output only k = 8 is 1; sof_out with k = 0.
REQ-032 Continuous: valid_in every cycle for 192 bits of random data -> 128 valid_out, no gaps, each block equals column-major permutation of preceding input block.
REQ-033 Gapped: valid_in every 3rd clk -> each valid_out exactly 1 clk after its valid_in after priming, same data as continuous case.
REQ-034 Misalignment: sof_in with valid_in at wcnt = 20 while primed -> sync_err pulse next clk, valid_out stops, resumes after 63 further valid_in, sof_out on first resumed bit.
REQ-035 Mid-block reset: rst = 0 at wcnt = 40 of block 2 -> outputs 0 next clk, full 64-bit refill required before valid_out.

Source files
------------

// File: rtl/block_interleaver_pkg.sv
// Shared comms parameters for the encoder -> interleaver -> modulator chain.
// Provides the default interleaver geometry and a helper to size block indices.
package block_interleaver_pkg;

  localparam int unsigned IlvRows  = 8;
  localparam int unsigned IlvCols  = 8;
  localparam int unsigned IlvN     = IlvRows * IlvCols;

  // Bits needed to index one block of n entries (n is a power of two).
  function automatic int unsigned ilv_addr_w(input int unsigned n);
    return $clog2(n);
  endfunction

  localparam int unsigned IlvAddrW = ilv_addr_w(IlvN);

endpackage

// File: rtl/interleave_addr_gen.sv
// Combinational index generator for the block interleaver.
// Ports:
//   wcnt_i : position within the current block (0..ROWS*COLS-1)
//   widx_o : row-major write index (row = wcnt/COLS, col = wcnt%COLS)
//   ridx_o : column-major read index (k%ROWS)*COLS + k/ROWS, k = wcnt
module interleave_addr_gen
  import block_interleaver_pkg::*;
#(
  parameter int unsigned ROWS = IlvRows,
  parameter int unsigned COLS = IlvCols
) (
  input  logic [ilv_addr_w(ROWS*COLS)-1:0] wcnt_i,
  output logic [ilv_addr_w(ROWS*COLS)-1:0] widx_o,
  output logic [ilv_addr_w(ROWS*COLS)-1:0] ridx_o
);

  localparam int unsigned RowBits = ilv_addr_w(ROWS);
  localparam int unsigned AddrW   = ilv_addr_w(ROWS*COLS);

  // Row-major storage means the write index is simply the counter.
  assign widx_o = wcnt_i;

  // With power-of-two geometry, (k%ROWS)*COLS + k/ROWS is a bit-field swap:
  // the low RowBits of k become the row, the remaining high bits the column.
  assign ridx_o = {wcnt_i[RowBits-1:0], wcnt_i[AddrW-1:RowBits]};

endmodule

// File: rtl/block_interleaver.sv
// Ping-pong block interleaver: bits are written row-major into one bank while
// the other bank (previous block) is read out column-major at the input rate.
// Output latency is exactly one block; a mid-block sof_in resynchronises.
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous active-low reset
//   bit_in    : input bit, qualified by valid_in
//   valid_in  : one-cycle strobe per input bit
//   sof_in    : first bit of an encoder block, qualified by valid_in
//   bit_out   : interleaved bit, holds its value between strobes
//   valid_out : one-cycle strobe per output bit
//   sof_out   : first bit of an interleaved block, qualified by valid_out
//   sync_err  : one-cycle pulse when sof_in arrives mid-block
module block_interleaver
  import block_interleaver_pkg::*;
#(
  parameter int unsigned ROWS = IlvRows,
  parameter int unsigned COLS = IlvCols
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic valid_in,
  input  logic sof_in,
  output logic bit_out,
  output logic valid_out,
  output logic sof_out,
  output logic sync_err
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned AW = ilv_addr_w(N);

  logic [AW-1:0] wcnt_q, wcnt_d;
  logic          wsel_q, wsel_d;
  logic          primed_q, primed_d;
  logic          bit_out_q, bit_out_d;
  logic          valid_out_q, valid_out_d;
  logic          sof_out_q, sof_out_d;
  logic          sync_err_q, sync_err_d;

  logic [AW-1:0] widx, ridx, wr_addr;
  logic          resync, last;

  // Both banks in one vector; the bank select is the MSB of the address.
  logic [2*N-1:0] mem_q;

  interleave_addr_gen #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_addr_gen (
    .wcnt_i (wcnt_q),
    .widx_o (widx),
    .ridx_o (ridx)
  );

  assign resync  = valid_in && sof_in && (wcnt_q != '0);
  assign last    = (wcnt_q == AW'(N - 1));
  assign wr_addr = resync ? '0 : widx;

  always_comb begin
    wcnt_d      = wcnt_q;
    wsel_d      = wsel_q;
    primed_d    = primed_q;
    bit_out_d   = bit_out_q;
    valid_out_d = 1'b0;
    sof_out_d   = 1'b0;
    sync_err_d  = 1'b0;
    if (valid_in) begin
      if (resync) begin
        // Realign: this bit becomes index 0, the read bank is no longer valid.
        wcnt_d     = AW'(1);
        primed_d   = 1'b0;
        sync_err_d = 1'b1;
      end else begin
        if (primed_q) begin
          bit_out_d   = mem_q[{~wsel_q, ridx}];
          valid_out_d = 1'b1;
          sof_out_d   = (wcnt_q == '0);
        end
        if (last) begin
          wcnt_d   = '0;
          wsel_d   = ~wsel_q;
          primed_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wcnt_q      <= '0;
      wsel_q      <= 1'b0;
      primed_q    <= 1'b0;
      bit_out_q   <= 1'b0;
      valid_out_q <= 1'b0;
      sof_out_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      wcnt_q      <= wcnt_d;
      wsel_q      <= wsel_d;
      primed_q    <= primed_d;
      bit_out_q   <= bit_out_d;
      valid_out_q <= valid_out_d;
      sof_out_q   <= sof_out_d;
      sync_err_q  <= sync_err_d;
    end
  end

  // Bank storage needs no reset; primed gates every read of stale contents.
  always_ff @(posedge clk) begin
    if (rst && valid_in) begin
      mem_q[{wsel_q, wr_addr}] <= bit_in;
    end
  end

  assign bit_out   = bit_out_q;
  assign valid_out = valid_out_q;
  assign sof_out   = sof_out_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_block_interleaver.sv
// Self-checking bench for block_interleaver: a block-level reference model
// (whole input blocks stored in arrays, output order from the permutation
// formula) predicts every output cycle under randomized data.
module tb_block_interleaver;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;
  localparam int unsigned N    = ROWS * COLS;

  logic clk = 1'b0;
  logic rst, bit_in, valid_in, sof_in;
  logic bit_out, valid_out, sof_out, sync_err;

  always #5 clk = ~clk;

  block_interleaver #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .valid_in  (valid_in),
    .sof_in    (sof_in),
    .bit_out   (bit_out),
    .valid_out (valid_out),
    .sof_out   (sof_out),
    .sync_err  (sync_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit blk  [N];
  bit prev [N];
  int inv  [N];   // inv[k] = input position j that appears at output position k
  int pos    = 0;
  bit primed = 0;
  bit last_b = 0;

  // Observation counters.
  int nvalid = 0;
  int k_obs  = 0;
  int ones   = 0;
  int one_k  = -1;
  bit saw_sof = 0;

  bit data [3*N];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic b, input logic s);
    bit ev, es, ee, eb;
    @(negedge clk);
    rst = r; valid_in = v; bit_in = b; sof_in = s;
    ev = 0; es = 0; ee = 0; eb = last_b;
    if (!r) begin
      eb = 0; pos = 0; primed = 0;
    end else if (v) begin
      if (s && pos != 0) begin
        blk[0] = b; pos = 1; primed = 0; ee = 1;
      end else begin
        if (primed) begin
          ev = 1; es = (pos == 0); eb = prev[inv[pos]];
        end
        blk[pos] = b;
        if (pos == N - 1) begin
          prev = blk; primed = 1; pos = 0;
        end else begin
          pos++;
        end
      end
    end
    last_b = eb;
    @(posedge clk);
    #1;
    check_eq("valid_out", 32'(valid_out), 32'(ev));
    check_eq("sof_out", 32'(sof_out), 32'(es));
    check_eq("sync_err", 32'(sync_err), 32'(ee));
    check_eq("bit_out", 32'(bit_out), 32'(eb));
    if (valid_out) begin
      nvalid++;
      k_obs = sof_out ? 0 : k_obs + 1;
      if (sof_out) saw_sof = 1;
      if (bit_out) begin ones++; one_k = k_obs; end
    end
  endtask

  initial begin
    for (int j = 0; j < int'(N); j++) inv[(j % COLS) * ROWS + j / COLS] = j;
    for (int i = 0; i < int'(3 * N); i++) data[i] = 1'($urandom_range(0, 1));
    rst = 0; valid_in = 0; bit_in = 0; sof_in = 0;

    // Reset held with valid_in toggling: outputs stay zero.
    for (int i = 0; i < 5; i++) step(0, 1'(i % 2), 1, 1'(i % 2));

    // Single-one block then a block of zeros.
    nvalid = 0;
    for (int j = 0; j < int'(N); j++) step(1, 1, 1'(j == 1), 1'(j == 0));
    check_eq("no_out_first_block", 32'(nvalid), 32'd0);
    ones = 0; one_k = -1; saw_sof = 0;
    for (int j = 0; j < int'(N); j++) step(1, 1, 0, 1'(j == 0));
    check_eq("single_one_count", 32'(ones), 32'd1);
    check_eq("single_one_pos", 32'(one_k), 32'd8);
    check_eq("single_one_sof", 32'(saw_sof), 32'd1);

    // Continuous random data after a fresh reset.
    step(0, 0, 0, 0);
    nvalid = 0;
    for (int i = 0; i < int'(3 * N); i++) step(1, 1, data[i], 1'(pos == 0));
    check_eq("continuous_count", 32'(nvalid), 32'd128);

    // Same data with a strobe every third clock.
    step(0, 0, 0, 0);
    nvalid = 0;
    for (int i = 0; i < int'(3 * N); i++) begin
      step(1, 1, data[i], 0);
      step(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check_eq("gapped_count", 32'(nvalid), 32'd128);

    // Misalignment at wcnt = 20 while primed.
    check_eq("primed_before_slip", 32'(primed), 32'd1);
    while (pos != 20) step(1, 1, 1'($urandom_range(0, 1)), 0);
    step(1, 1, 1'($urandom_range(0, 1)), 1);
    nvalid = 0;
    for (int i = 0; i < 63; i++) step(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) & 1'(pos == 0));
    check_eq("slip_gap", 32'(nvalid), 32'd0);
    saw_sof = 0;
    step(1, 1, 1'($urandom_range(0, 1)), 0);
    check_eq("slip_resume_valid", 32'(nvalid), 32'd1);
    check_eq("slip_resume_sof", 32'(saw_sof), 32'd1);

    // Reset at wcnt = 40 of block 2, then a full refill.
    for (int i = 0; i < int'(N) + 39; i++) step(1, 1, 1'($urandom_range(0, 1)), 0);
    check_eq("pos_before_reset", 32'(pos), 32'd40);
    step(0, 1, 1, 1);
    nvalid = 0;
    for (int i = 0; i < int'(N); i++) step(1, 1, 1'($urandom_range(0, 1)), 0);
    check_eq("refill_no_out", 32'(nvalid), 32'd0);
    for (int i = 0; i < 16; i++) step(1, 1, 1'($urandom_range(0, 1)), 0);
    check_eq("refill_resume", 32'(nvalid), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
